i2c_byte_seq: RTL and testbench

I2C_BYTE_SEQ -- requirements
Module: i2c_byte_seq

---
 rtl/i2c_byte_seq.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_byte_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_seq.sv
// i2c_byte_seq: moves one byte over an I2C bus, optionally framed by START
// and/or STOP. Data comes from or goes to an external shift register through
// the sr_* strobes. Between transfers without a STOP, SCL is parked low (HOLD).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | bus released, waiting for start
// S_HOLD  | previous transfer ended without STOP, SCL held low
// S_START | START / repeated START, 4 quarters
// S_BIT   | 8 data bits MSB first, 4 quarters per bit
// S_ACK   | ninth (acknowledge) bit, 4 quarters
// S_STOP  | STOP condition, 3 quarters, then S_IDLE

module i2c_byte_seq #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic rw,
    input  logic gen_start,
    input  logic gen_stop,
    input  logic ack_n,
    input  logic sda_in,
    input  logic sr_out,
    output logic scl,
    output logic sda_oe,
    output logic sr_set,
    output logic sr_en,
    output logic sr_rw,
    output logic sr_in,
    output logic rx_ack,
    output logic busy,
    output logic done,
    output logic bus_held
);

    localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP
    } state_t;

    state_t        state, state_n;
    logic [1:0]    phase, phase_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [TW-1:0] timer;
    logic          qtick;
    logic          accept;
    logic          rw_q, rw_n;
    logic          stop_q, stop_n;
    logic          ackn_q, ackn_n;
    logic          rx_ack_n, busy_n, done_n, held_n;

    // A request landing in the done cycle is dropped; the requester re-issues it.
    assign accept = start && !done && !clr && ((state == S_IDLE) || (state == S_HOLD));
    assign sr_set = accept;
    assign sr_rw  = rw_q;
    assign qtick  = busy && (timer == T_LAST);

    // Quarter-period timer: runs only while busy, restarts on every accept.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            timer <= '0;
        end else if (accept || !busy || qtick) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // State, counters, captured request fields and status flags.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            rw_q     <= 1'b0;
            stop_q   <= 1'b0;
            ackn_q   <= 1'b1;
            rx_ack   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            bus_held <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            bit_cnt  <= bit_cnt_n;
            rw_q     <= rw_n;
            stop_q   <= stop_n;
            ackn_q   <= ackn_n;
            rx_ack   <= rx_ack_n;
            busy     <= busy_n;
            done     <= done_n;
            bus_held <= held_n;
        end
    end

    // Next-state logic and bus/shift-register outputs per state and quarter.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        bit_cnt_n = bit_cnt;
        rw_n      = rw_q;
        stop_n    = stop_q;
        ackn_n    = ackn_q;
        rx_ack_n  = rx_ack;
        busy_n    = busy;
        done_n    = 1'b0;
        held_n    = bus_held;
        scl       = 1'b1;
        sda_oe    = 1'b0;
        sr_en     = 1'b0;
        sr_in     = 1'b0;

        case (state)
            S_IDLE, S_HOLD: begin
                scl = (state == S_IDLE);
                if (accept) begin
                    rw_n      = rw;
                    stop_n    = gen_stop;
                    ackn_n    = ack_n;
                    busy_n    = 1'b1;
                    phase_n   = '0;
                    bit_cnt_n = '0;
                    state_n   = gen_start ? S_START : S_BIT;
                end
            end

            S_START: begin
                // From HOLD, SCL stays low in Q0 so the repeated START is clean.
                scl    = (phase == 2'd0) ? ~bus_held : 1'b1;
                sda_oe = phase[1];
                if (qtick) begin
                    phase_n = phase + 2'd1;
                    if (phase == 2'd3) begin
                        state_n = S_BIT;
                    end
                end
            end

            S_BIT: begin
                scl = phase[1];
                if (rw_q) begin
                    sr_in = sda_in;
                    sr_en = qtick && (phase == 2'd2);
                end else begin
                    sda_oe = ~sr_out;
                    sr_en  = qtick && (phase == 2'd3);
                end
                if (qtick) begin
                    phase_n = phase + 2'd1;
                    if (phase == 2'd3) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_n = S_ACK;
                        end
                    end
                end
            end

            S_ACK: begin
                scl = phase[1];
                if (rw_q) begin
                    sda_oe = ~ackn_q;
                end else if (qtick && (phase == 2'd2)) begin
                    rx_ack_n = sda_in;
                end
                if (qtick) begin
                    phase_n = phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (stop_q) begin
                            state_n = S_STOP;
                        end else begin
                            state_n = S_HOLD;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            held_n  = 1'b1;
                        end
                    end
                end
            end

            S_STOP: begin
                scl    = (phase != 2'd0);
                sda_oe = (phase != 2'd2);
                if (qtick) begin
                    if (phase == 2'd2) begin
                        state_n = S_IDLE;
                        phase_n = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        held_n  = 1'b0;
                    end else begin
                        phase_n = phase + 2'd1;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_byte_seq.sv
// Bench for i2c_byte_seq: external shift register and slave models, a
// negedge bus monitor feeding a scoreboard of expected per-transfer results.

module tb_i2c_byte_seq;

    localparam int CLK_DIV = 4;

    typedef struct {
        logic       rw;
        logic       gs;
        logic       gp;
        logic       ack_n;
        logic [7:0] data;
        logic       slv_ack;
        logic [7:0] exp_bits;
        logic       exp_rx;
        int         exp_lat;
        logic       exp_held;
    } vec_t;

    typedef struct {
        int bits;
        int rx_ack;
        int lat;
        int held;
        int starts;
        int stops;
        int ack_drv;
        int q0_scl;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic start = 1'b0;
    logic rw = 1'b0;
    logic gen_start = 1'b0;
    logic gen_stop = 1'b0;
    logic ack_n = 1'b1;
    logic sda_in;
    logic sr_out;
    logic scl, sda_oe, sr_set, sr_en, sr_rw, sr_in, rx_ack, busy, done, bus_held;

    i2c_byte_seq #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .rw        (rw),
        .gen_start (gen_start),
        .gen_stop  (gen_stop),
        .ack_n     (ack_n),
        .sda_in    (sda_in),
        .sr_out    (sr_out),
        .scl       (scl),
        .sda_oe    (sda_oe),
        .sr_set    (sr_set),
        .sr_en     (sr_en),
        .sr_rw     (sr_rw),
        .sr_in     (sr_in),
        .rx_ack    (rx_ack),
        .busy      (busy),
        .done      (done),
        .bus_held  (bus_held)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input int act, input int want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // external shift register and bus slave
    logic [7:0] sr_q = 8'h00;
    logic [7:0] tx_byte = 8'h00;
    logic [7:0] slv_byte = 8'h00;
    logic       slv_ack = 1'b1;
    logic       cur_rw = 1'b0;
    logic       slv_sda;
    int         en_cnt = 0;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sr_set) begin
            sr_q   <= tx_byte;
            en_cnt <= 0;
        end else if (sr_en) begin
            sr_q   <= {sr_q[6:0], sr_in};
            en_cnt <= en_cnt + 1;
        end
    end

    assign sr_out = sr_q[7];

    always_comb begin
        slv_sda = 1'b1;
        if (en_cnt < 8) begin
            if (cur_rw) slv_sda = slv_byte[3'(7 - en_cnt)];
        end else if (!cur_rw) begin
            slv_sda = slv_ack;
        end
    end

    assign sda_in = ~sda_oe & slv_sda;

    // monitor / scoreboard
    exp_t       sb_q[$];
    exp_t       mon_e;
    int         acc_edge = -1;
    int         en_pulses = 0;
    int         starts = 0;
    int         stops = 0;
    int         sr_set_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] bits = 8'h00;
    logic       ack_drv = 1'b0;
    logic       ack_seen = 1'b0;
    logic       q0_scl = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_oe = 1'b0;

    always @(negedge clk) begin
        if (sr_set) begin
            sr_set_cnt++;
            acc_edge  = cyc + 1;
            en_pulses = 0;
            bits      = 8'h00;
            starts    = 0;
            stops     = 0;
            ack_seen  = 1'b0;
            ack_drv   = 1'b0;
        end
        if (cyc == acc_edge) q0_scl = scl;
        if (sr_en) begin
            en_pulses++;
            bits = {bits[6:0], (cur_rw ? sr_in : sda_in)};
        end
        if (prev_scl && scl && (prev_oe != sda_oe)) begin
            if (sda_oe) starts++;
            else        stops++;
        end
        if ((en_pulses == 8) && !prev_scl && scl && !ack_seen) begin
            ack_drv  = sda_oe;
            ack_seen = 1'b1;
        end
        prev_scl = scl;
        prev_oe  = sda_oe;
        if (done) begin
            done_cnt++;
            check("sb_pending", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("bits", int'(bits), mon_e.bits);
                check("rx_ack", int'(rx_ack), mon_e.rx_ack);
                check("latency", cyc - acc_edge, mon_e.lat);
                check("bus_held", int'(bus_held), mon_e.held);
                check("scl_after", int'(scl), 1 - mon_e.held);
                check("busy_at_done", int'(busy), 0);
                check("sr_en_pulses", en_pulses, 8);
                check("start_conds", starts, mon_e.starts);
                check("stop_conds", stops, mon_e.stops);
                check("ack_drive", int'(ack_drv), mon_e.ack_drv);
                check("q0_scl", int'(q0_scl), mon_e.q0_scl);
            end
        end
    end

    logic held_model = 1'b0;

    task automatic run_vec(input vec_t v, input bit hold);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        rw        = v.rw;
        gen_start = v.gs;
        gen_stop  = v.gp;
        ack_n     = v.ack_n;
        cur_rw    = v.rw;
        tx_byte   = v.rw ? 8'h00 : v.data;
        slv_byte  = v.data;
        slv_ack   = v.slv_ack;
        e.bits    = int'(v.exp_bits);
        e.rx_ack  = int'(v.exp_rx);
        e.lat     = v.exp_lat;
        e.held    = int'(v.exp_held);
        e.starts  = int'(v.gs);
        e.stops   = int'(v.gp);
        e.ack_drv = int'(v.rw & ~v.ack_n);
        e.q0_scl  = int'(v.gs & ~held_model);
        sb_q.push_back(e);
        held_model = v.exp_held;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            start     = 1'b0;
            rw        = ~rw;
            gen_start = ~gen_start;
            gen_stop  = ~gen_stop;
            ack_n     = ~ack_n;
        end
        got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("done_seen", int'(got), 1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    vec_t vt[8];
    vec_t v_post;
    vec_t v_hold;
    int   d0;
    int   s0;

    initial begin
        vt[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8'hA5, 1'b0, 172, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b0, 160, 1'b1};
        vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1, 160, 1'b1};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 8'hC3, 1'b0, 156, 1'b0};
        vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h81, 1'b1, 8'h81, 1'b0, 156, 1'b0};
        vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 172, 1'b0};
        vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 160, 1'b1};
        vt[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 8'h7E, 1'b1, 156, 1'b0};
        v_post = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h69, 1'b0, 8'h69, 1'b0, 172, 1'b0};
        v_hold = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hD2, 1'b1, 8'hD2, 1'b0, 172, 1'b0};

        // reset state, with a start request pending during clr
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", int'(scl), 1);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_sr_set", int'(sr_set), 0);
        check("rst_sr_en", int'(sr_en), 0);
        check("rst_sr_rw", int'(sr_rw), 0);
        check("rst_sr_in", int'(sr_in), 0);
        check("rst_rx_ack", int'(rx_ack), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bus_held", int'(bus_held), 0);
        start = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vt[i], 1'b0);
        end

        // clr in the middle of data bit 4
        @(posedge clk); #1;
        rw = 1'b0; gen_start = 1'b1; gen_stop = 1'b1; ack_n = 1'b1;
        cur_rw = 1'b0; tx_byte = 8'h96; slv_ack = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 300 && en_cnt != 4; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("clr_at_bit4", en_cnt, 4);
        d0 = done_cnt;
        clr = 1'b1;
        #1;
        check("clr_scl", int'(scl), 1);
        check("clr_sda_oe", int'(sda_oe), 0);
        check("clr_busy", int'(busy), 0);
        check("clr_sr_en", int'(sr_en), 0);
        check("clr_rx_ack", int'(rx_ack), 1);
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (200) @(negedge clk);
        check("clr_no_done", done_cnt, d0);
        held_model = 1'b0;
        run_vec(v_post, 1'b0);

        // start held through the whole transfer, including the done cycle
        s0 = sr_set_cnt;
        d0 = done_cnt;
        run_vec(v_hold, 1'b1);
        @(negedge clk);
        check("held_sr_set_cnt", sr_set_cnt - s0, 1);
        check("held_done_cnt", done_cnt - d0, 1);
        check("held_busy_after", int'(busy), 0);
        repeat (4) @(negedge clk);
        check("held_idle_scl", int'(scl), 1);

        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
